// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control/display bundle: pulse requests in, displayed digits and status out.
interface stopwatch_ctrl_if #(
  parameter int MIN_RADIX = 60
);
  localparam int MW = $clog2(MIN_RADIX);

  logic          start_stop;
  logic          lap_clear;
  logic [6:0]    centi;
  logic [5:0]    sec;
  logic [MW-1:0] min;
  logic          running;
  logic          lap_active;
  logic          overflow;

  modport master (
    output start_stop, lap_clear,
    input  centi, sec, min, running, lap_active, overflow
  );

  modport slave (
    input  start_stop, lap_clear,
    output centi, sec, min, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch: prescaled 1/100 s tick driving a centi/sec/min cascade with run/pause/clear control.
// Define STOPWATCH_LAP_HOLD_EN to add the LAP state that freezes the display on a snapshot.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int MIN_RADIX = 60
) (
  input logic        clock,
  input logic        reset,
  stopwatch_ctrl_if.slave sw
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int MW = $clog2(MIN_RADIX);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MIN_MAX   = MW'(MIN_RADIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
`ifdef STOPWATCH_LAP_HOLD_EN
    , S_LAP
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    centi_q, centi_d;
  logic [5:0]    sec_q, sec_d;
  logic [MW-1:0] min_q, min_d;
  logic          ovf_q, ovf_d;
  logic          counting, tick, clear;
  logic          centi_carry, sec_carry, min_carry;

  // start_stop is tested first in every state so it wins over a coincident lap_clear
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE:  if (sw.start_stop) state_d = S_RUN;
      S_RUN: begin
        if (sw.start_stop) state_d = S_PAUSE;
`ifdef STOPWATCH_LAP_HOLD_EN
        else if (sw.lap_clear) state_d = S_LAP;
`endif
      end
      S_PAUSE: begin
        if (sw.start_stop) state_d = S_RUN;
        else if (sw.lap_clear) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
`ifdef STOPWATCH_LAP_HOLD_EN
      S_LAP: begin
        if (sw.start_stop) state_d = S_PAUSE;
        else if (sw.lap_clear) state_d = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);
`else
  assign counting = (state_q == S_RUN);
`endif
  assign tick        = counting && (presc_q == PRESC_MAX);
  assign centi_carry = tick && (centi_q == 7'd99);
  assign sec_carry   = centi_carry && (sec_q == 6'd59);
  assign min_carry   = sec_carry && (min_q == MIN_MAX);

  always_comb begin
    presc_d = presc_q;
    centi_d = centi_q;
    sec_d   = sec_q;
    min_d   = min_q;
    ovf_d   = ovf_q;
    if (counting) presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    if (tick) centi_d = centi_carry ? '0 : centi_q + 7'd1;
    if (centi_carry) sec_d = sec_carry ? '0 : sec_q + 6'd1;
    if (sec_carry) min_d = min_carry ? '0 : min_q + 1'b1;
    if (min_carry) ovf_d = 1'b1;
    if (clear) begin
      presc_d = '0;
      centi_d = '0;
      sec_d   = '0;
      min_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      centi_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      centi_q <= centi_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic [6:0]    snap_centi_q, snap_centi_d;
  logic [5:0]    snap_sec_q, snap_sec_d;
  logic [MW-1:0] snap_min_q, snap_min_d;
  logic          in_lap;

  // Snapshot takes the pre-tick digits of the cycle that requests LAP
  always_comb begin
    snap_centi_d = snap_centi_q;
    snap_sec_d   = snap_sec_q;
    snap_min_d   = snap_min_q;
    if ((state_q == S_RUN) && (state_d == S_LAP)) begin
      snap_centi_d = centi_q;
      snap_sec_d   = sec_q;
      snap_min_d   = min_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_centi_q <= '0;
      snap_sec_q   <= '0;
      snap_min_q   <= '0;
    end else begin
      snap_centi_q <= snap_centi_d;
      snap_sec_q   <= snap_sec_d;
      snap_min_q   <= snap_min_d;
    end
  end

  assign in_lap        = (state_q == S_LAP);
  assign sw.centi      = in_lap ? snap_centi_q : centi_q;
  assign sw.sec        = in_lap ? snap_sec_q   : sec_q;
  assign sw.min        = in_lap ? snap_min_q   : min_q;
  assign sw.lap_active = in_lap;
`else
  assign sw.centi      = centi_q;
  assign sw.sec        = sec_q;
  assign sw.min        = min_q;
  assign sw.lap_active = 1'b0;
`endif

  assign sw.running  = counting;
  assign sw.overflow = ovf_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=4, MIN_RADIX=3) against an elapsed-tick model.
module tb_stopwatch_ctrl;
  localparam int TDIV = 4;
  localparam int MINR = 3;
  localparam int WRAP = 100 * 60 * MINR;
`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stopwatch_ctrl_if #(.MIN_RADIX(MINR)) sw ();

  stopwatch_ctrl #(.TICK_DIV(TDIV), .MIN_RADIX(MINR)) dut (
    .clock(clock),
    .reset(reset),
    .sw   (sw)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model: elapsed ticks since clear, phase within the current tick, and a lap snapshot
  int m_mode  = M_IDLE;
  int m_phase = 0;
  int m_ticks = 0;
  int m_snap  = 0;
  bit m_ovf   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit ss, input bit lc, input bit rs);
    bit cnt, tk;
    int pre;
    if (rs) begin
      m_mode = M_IDLE; m_phase = 0; m_ticks = 0; m_snap = 0; m_ovf = 1'b0;
      return;
    end
    pre = m_ticks;
    cnt = (m_mode == M_RUN) || (m_mode == M_LAP);
    tk  = cnt && (m_phase == TDIV - 1);
    if (cnt) m_phase = (m_phase + 1) % TDIV;
    if (tk) begin
      m_ticks = (m_ticks + 1) % WRAP;
      if (m_ticks == 0) m_ovf = 1'b1;
    end
    case (m_mode)
      M_IDLE:  if (ss) m_mode = M_RUN;
      M_RUN: begin
        if (ss) m_mode = M_PAUSE;
        else if (lc && LAP_EN) begin m_mode = M_LAP; m_snap = pre; end
      end
      M_PAUSE: begin
        if (ss) m_mode = M_RUN;
        else if (lc) begin m_mode = M_IDLE; m_ticks = 0; m_phase = 0; m_ovf = 1'b0; end
      end
      default: begin
        if (ss) m_mode = M_PAUSE;
        else if (lc) m_mode = M_RUN;
      end
    endcase
  endtask

  task automatic cyc(input bit ss, input bit lc, input bit rs);
    sw.start_stop = ss;
    sw.lap_clear  = lc;
    reset         = rs;
    @(posedge clock);
    model_step(ss, lc, rs);
    #1;
    sw.start_stop = 1'b0;
    sw.lap_clear  = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clock) begin
    int d;
    if (chk_en) begin
      d = (m_mode == M_LAP) ? m_snap : m_ticks;
      check("centi", int'(sw.centi), d % 100);
      check("sec", int'(sw.sec), (d / 100) % 60);
      check("min", int'(sw.min), d / 6000);
      check("running", int'(sw.running), int'((m_mode == M_RUN) || (m_mode == M_LAP)));
      check("lap_active", int'(sw.lap_active), int'(m_mode == M_LAP));
      check("overflow", int'(sw.overflow), int'(m_ovf));
    end
  end

  initial begin
    sw.start_stop = 1'b0;
    sw.lap_clear  = 1'b0;
    reset         = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    check("rst_centi", int'(sw.centi), 0);
    check("rst_running", int'(sw.running), 0);
    check("rst_overflow", int'(sw.overflow), 0);

    // Counting: first tick on the 4th running cycle, 100 ticks in 400 cycles
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(3);
    check("cnt_before_tick", int'(sw.centi), 0);
    idle_n(1);
    check("cnt_first_tick", int'(sw.centi), 1);
    idle_n(396);
    check("cnt_centi", int'(sw.centi), 0);
    check("cnt_sec", int'(sw.sec), 1);
    check("cnt_running", int'(sw.running), 1);

    // Pause with prescaler mid-phase, resume finishes the remaining phase
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(42);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(100);
    check("pause_hold", int'(sw.centi), 10);
    check("pause_running", int'(sw.running), 0);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(1);
    check("resume_short_tick", int'(sw.centi), 11);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("clear_centi", int'(sw.centi), 0);
    check("clear_running", int'(sw.running), 0);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(3);
    check("clear_presc_zero", int'(sw.centi), 0);
    idle_n(1);
    check("clear_full_tick", int'(sw.centi), 1);

    // Simultaneous pulses in RUN: start_stop wins
    cyc(1'b1, 1'b1, 1'b0);
    check("simul_running", int'(sw.running), 0);
    check("simul_lap", int'(sw.lap_active), 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("simul_resumed", int'(sw.running), 1);

    // Lap hold
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(100);
    check("lap_pre", int'(sw.centi), 25);
    cyc(1'b0, 1'b1, 1'b0);
    check("lap_entry_centi", int'(sw.centi), 25);
    check("lap_entry_active", int'(sw.lap_active), int'(LAP_EN));
    idle_n(80);
    check("lap_frozen", int'(sw.centi), LAP_EN ? 25 : 45);
    cyc(1'b0, 1'b1, 1'b0);
    check("lap_exit_centi", int'(sw.centi), 45);
    check("lap_exit_active", int'(sw.lap_active), 0);

    // Reset mid-run beats a coincident start_stop
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(148);
    check("mid_pre", int'(sw.centi), 37);
    sw.start_stop = 1'b1;
    reset         = 1'b1;
    #2;
    check("mid_between_edges", int'(sw.centi), 37);
    @(posedge clock);
    model_step(1'b1, 1'b0, 1'b1);
    #1;
    sw.start_stop = 1'b0;
    reset         = 1'b0;
    check("mid_rst_centi", int'(sw.centi), 0);
    check("mid_rst_running", int'(sw.running), 0);
    idle_n(10);
    check("mid_stays_idle", int'(sw.centi), 0);

    // Full wrap: 18000 ticks
    cyc(1'b1, 1'b0, 1'b0);
    idle_n(WRAP * TDIV - 4);
    check("ovf_pre_centi", int'(sw.centi), 99);
    check("ovf_pre_sec", int'(sw.sec), 59);
    check("ovf_pre_min", int'(sw.min), 2);
    check("ovf_pre_flag", int'(sw.overflow), 0);
    idle_n(4);
    check("ovf_centi", int'(sw.centi), 0);
    check("ovf_sec", int'(sw.sec), 0);
    check("ovf_min", int'(sw.min), 0);
    check("ovf_flag", int'(sw.overflow), 1);
    idle_n(4);
    check("ovf_continue", int'(sw.centi), 1);
    check("ovf_sticky", int'(sw.overflow), 1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("ovf_cleared", int'(sw.overflow), 0);
    idle_n(2);

    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
